// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash READ sequencer.
// Holds state encodings, the default command byte and address helpers.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ_DEF = 8'h03;
  localparam int         ADDR_BYTES   = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_READ = 3'd3,
    ST_HOLD = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_ISSUE   = 2'd0,
    PH_WAIT_HI = 2'd1,
    PH_WAIT_LO = 2'd2
  } phase_t;

  // Address bytes go out MSB first.
  function automatic logic [7:0] addr_byte(
    input logic [23:0] a,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    unique case (1'b1)
      (idx == 2'd0): b = a[23:16];
      (idx == 2'd1): b = a[15:8];
      default:       b = a[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// SPI NOR READ (0x03) sequencer driving a byte-level SPI engine.
// Ports: I_start/I_addr/I_len request, O_busy/O_done status,
// O_data/O_data_valid/I_data_ready stream, O_spi_* / I_spi_* engine side.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
  parameter int         LEN_WIDTH = 16,
  parameter int         CS_GAP    = 2
) (
  input  logic                 I_clk,
  input  logic                 I_reset_n,
  input  logic                 I_start,
  input  logic [23:0]          I_addr,
  input  logic [LEN_WIDTH-1:0] I_len,
  output logic                 O_busy,
  output logic                 O_done,
  output logic [7:0]           O_data,
  output logic                 O_data_valid,
  input  logic                 I_data_ready,
  output logic                 O_spi_cs_n,
  output logic [7:0]           O_spi_tx_data,
  output logic                 O_spi_tx_start,
  input  logic                 I_spi_busy,
  input  logic [7:0]           I_spi_rx_data
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [1:0] LAST_IDX = 2'(ADDR_BYTES - 1);

  state_t               state_q, state_d;
  phase_t               phase_q, phase_d;
  logic [23:0]          addr_q, addr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [1:0]           idx_q, idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cs_q, cs_d;
  logic [7:0]           txd_q, txd_d;
  logic                 txs_q, txs_d;
  logic [7:0]           data_q, data_d;
  logic                 vld_q, vld_d;
  logic [7:0]           cur_byte;
  logic                 byte_done;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_d      = cs_q;
    txd_d     = txd_q;
    txs_d     = 1'b0;
    data_d    = data_q;
    vld_d     = vld_q;
    byte_done = 1'b0;

    unique case (state_q)
      ST_CMD:  cur_byte = CMD_READ;
      ST_ADDR: cur_byte = addr_byte(addr_q, idx_q);
      default: cur_byte = 8'h00;
    endcase

    // Shared per-byte handshake; tx data stays put
    // until the next issue since the engine latches late.
    if (state_q inside {ST_CMD, ST_ADDR, ST_READ}) begin
      unique case (phase_q)
        PH_ISSUE: begin
          txs_d   = 1'b1;
          txd_d   = cur_byte;
          phase_d = PH_WAIT_HI;
        end
        PH_WAIT_HI: begin
          if (I_spi_busy) phase_d = PH_WAIT_LO;
        end
        PH_WAIT_LO: begin
          if (!I_spi_busy) begin
            byte_done = 1'b1;
            phase_d   = PH_ISSUE;
          end
        end
        default: phase_d = PH_ISSUE;
      endcase
    end

    unique case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          addr_d  = I_addr;
          rem_d   = I_len;
          busy_d  = 1'b1;
          phase_d = PH_ISSUE;
          idx_d   = 2'd0;
          if (I_len == '0) begin
            gap_d   = GW'(CS_GAP - 1);
            state_d = ST_GAP;
          end else begin
            cs_d    = 1'b0;
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (byte_done) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (byte_done) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 2'd0;
            state_d = ST_READ;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_READ: begin
        if (byte_done) begin
          data_d  = I_spi_rx_data;
          vld_d   = 1'b1;
          rem_d   = rem_q - LEN_WIDTH'(1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // No new byte is started until the
        // consumer has taken the current one.
        if (I_data_ready) begin
          vld_d = 1'b0;
          if (rem_q != '0) begin
            state_d = ST_READ;
          end else begin
            cs_d    = 1'b1;
            gap_d   = GW'(CS_GAP - 1);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= PH_ISSUE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      txd_q   <= '0;
      txs_q   <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign O_busy         = busy_q;
  assign O_done         = done_q;
  assign O_data         = data_q;
  assign O_data_valid   = vld_q;
  assign O_spi_cs_n     = cs_q;
  assign O_spi_tx_data  = txd_q;
  assign O_spi_tx_start = txs_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a behavioural SPI engine.
// Table-driven requests plus glitch and mid-transfer reset sequences.
module tb_spi_flash_reader;

  localparam int CS_GAP   = 2;
  localparam int BUSY_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] len = '0;
  logic        ready = 1'b0;
  logic        eng_busy = 1'b0;
  logic [7:0]  eng_rx = 8'h00;
  logic        busy, done, data_valid, cs_n, tx_start;
  logic [7:0]  data, tx_data;

  spi_flash_reader #(.CS_GAP(CS_GAP)) dut (
    .I_clk(clk), .I_reset_n(rst_n),
    .I_start(start), .I_addr(addr), .I_len(len),
    .O_busy(busy), .O_done(done),
    .O_data(data), .O_data_valid(data_valid),
    .I_data_ready(ready),
    .O_spi_cs_n(cs_n), .O_spi_tx_data(tx_data),
    .O_spi_tx_start(tx_start),
    .I_spi_busy(eng_busy), .I_spi_rx_data(eng_rx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing", name);
  endtask

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rsp_q[$];

  // Engine: busy one cycle after start, for BUSY_LEN cycles;
  // rx byte appears as busy falls. Not reset by the DUT.
  int         eng_cnt = 0;
  logic [7:0] eng_r;
  always @(posedge clk) begin
    if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        if (rsp_q.size() != 0) eng_r = rsp_q.pop_front();
        else eng_r = 8'hEE;
        eng_busy <= 1'b0;
        eng_rx   <= eng_r;
      end
    end else if (tx_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= BUSY_LEN;
    end
  end

  int         cyc = 0, start_cnt = 0, done_cnt = 0;
  int         cs_rise_cyc = 0, done_cyc = 0;
  bit         cs_low_seen = 0, tracking = 0;
  bit         seen_busy = 0, hold_err = 0;
  bit         prev_valid = 0, prev_hs = 0;
  logic       prev_cs_n = 1'b1;
  logic [7:0] cap, prev_data;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      tracking   = 0;
      prev_valid = 0;
      prev_cs_n  = 1'b1;
    end else begin
      if (!cs_n) cs_low_seen = 1;
      if (cs_n && !prev_cs_n) cs_rise_cyc = cyc;
      prev_cs_n = cs_n;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy", busy, 0);
      end
      if (tracking) begin
        if (tx_data !== cap) hold_err = 1;
        if (eng_busy) seen_busy = 1;
        else if (seen_busy) begin
          tracking = 0;
          check("tx_hold", hold_err, 0);
          if (exp_tx.size() == 0) fail("tx_extra");
          else check("tx_byte", tx_data, exp_tx.pop_front());
        end
      end
      if (tx_start) begin
        start_cnt++;
        check("start_while_valid", data_valid, 0);
        tracking  = 1;
        seen_busy = 0;
        hold_err  = 0;
        cap       = tx_data;
      end
      if (prev_valid && !prev_hs) begin
        check("valid_hold", data_valid, 1);
        check("data_hold", data, prev_data);
      end
      if (data_valid && ready) begin
        if (exp_rx.size() == 0) fail("rx_extra");
        else check("rx_byte", data, exp_rx.pop_front());
      end
      prev_valid = data_valid;
      prev_hs    = data_valid && ready;
      prev_data  = data;
    end
  end

  // Consumer: ready high, or low for 'stall' cycles per byte.
  int stall = 0;
  int wcnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (stall == 0) ready = 1'b1;
    else if (data_valid) begin
      if (wcnt >= stall) ready = 1'b1;
      else begin
        ready = 1'b0;
        wcnt++;
      end
    end else begin
      ready = 1'b0;
      wcnt  = 0;
    end
  end

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    int          stall;
    logic [7:0]  seed;
    int          exp_starts;
  } vec_t;

  vec_t vecs[5];

  task automatic push_req(input logic [23:0] a,
                          input logic [15:0] n,
                          input logic [7:0] seed);
    logic [7:0] b;
    if (n != 0) begin
      exp_tx.push_back(8'h03);
      exp_tx.push_back(a[23:16]);
      exp_tx.push_back(a[15:8]);
      exp_tx.push_back(a[7:0]);
      repeat (4) rsp_q.push_back(8'hFF);
    end
    for (int i = 0; i < int'(n); i++) begin
      exp_tx.push_back(8'h00);
      b = (i[0] ? ~seed : seed) + 8'(i >> 1);
      rsp_q.push_back(b);
      exp_rx.push_back(b);
    end
  endtask

  task automatic pulse_start(input logic [23:0] a,
                             input logic [15:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    addr  = a;
    len   = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_req(input vec_t v, input int glitch_at);
    bit got;
    int n;
    start_cnt   = 0;
    done_cnt    = 0;
    cs_low_seen = 0;
    stall       = v.stall;
    push_req(v.addr, v.len, v.seed);
    pulse_start(v.addr, v.len);
    check("busy_on_accept", busy, 1);
    check("cs_on_accept", cs_n, v.len == 0);
    got = 0;
    n   = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      if (c == glitch_at) begin
        start = 1'b1;
        addr  = ~v.addr;
        len   = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (c == 0 && v.len != 0)
        check("first_tx_start", tx_start, 1);
      if (done) got = 1;
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    if (!got) fail("done_timeout");
    else if (v.len == 0) check("len0_latency", n, CS_GAP);
    else check("cs_gap", done_cyc - cs_rise_cyc, CS_GAP);
    check("starts", start_cnt, v.exp_starts);
    check("dones", done_cnt, 1);
    check("cs_low_seen", cs_low_seen, v.len != 0);
    check("tx_left", exp_tx.size(), 0);
    check("rx_left", exp_rx.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{24'h123456, 16'd2, 0, 8'hA5, 6};
    vecs[1] = '{24'h000000, 16'd0, 0, 8'h00, 0};
    vecs[2] = '{24'hABCDEF, 16'd3, 20, 8'h3C, 7};
    vecs[3] = '{24'hFFFFFF, 16'd1, 0, 8'h81, 5};
    vecs[4] = '{24'h00FF00, 16'd4, 2, 8'h10, 8};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          {cs_n, tx_start, tx_data, data, data_valid, busy, done},
          {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_state",
          {cs_n, tx_start, data_valid, busy, done},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 5; i++) run_req(vecs[i], -1);

    v = '{24'h345678, 16'd2, 5, 8'h77, 6};
    run_req(v, 10);

    // Reset while the address bytes are going out.
    start_cnt = 0;
    stall     = 0;
    push_req(24'h0F1E2D, 16'd2, 8'h5E);
    pulse_start(24'h0F1E2D, 16'd2);
    for (int c = 0; c < 200 && start_cnt < 2; c++) begin
      @(posedge clk);
      #1;
    end
    if (start_cnt < 2) fail("addr_phase_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async",
          {cs_n, tx_start, tx_data, data, data_valid, busy, done},
          {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
    for (int c = 0; c < 50 && eng_busy; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_cs", cs_n, 1);
    exp_tx.delete();
    exp_rx.delete();
    rsp_q.delete();
    rst_n = 1'b1;
    v = '{24'h0F1E2D, 16'd2, 0, 8'hC3, 6};
    run_req(v, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Transaction sequencer that drives the byte-level SPI engine (`spicontroller`) to perform SPI NOR flash READ (0x03) transfers. It owns chip-select and issues command, 24-bit address and dummy bytes to the engine. Received bytes are streamed to a consumer over a valid/ready handshake. It sits between the boot/ROM loader (requester) and the single SPI engine instance.

## Interface
Parameters:
- CMD_READ, 8'h03, command byte sent first.
- LEN_WIDTH, 16, width of byte-count request.
- CS_GAP, 2, minimum cycles O_spi_cs_n stays high after a transfer before O_done and return to idle (≥1).

Ports:
- I_clk  in  1  system clock; single clock domain.
- I_reset_n  in  1  reset, asynchronous assert, active-low.
- I_start  in  1  request pulse; sampled only in IDLE.
- I_addr  in  24  flash start address, captured on accepted I_start.
- I_len  in  LEN_WIDTH  number of data bytes, captured on accepted I_start.
- O_busy  out  1  transfer in progress.
- O_done  out  1  one-cycle completion pulse.
- O_data  out  8  received byte.
- O_data_valid  out  1  O_data valid; held until consumed.
- I_data_ready  in  1  consumer accepts O_data when high with O_data_valid.
- O_spi_cs_n  out  1  flash chip select, active-low.
- O_spi_tx_data  out  8  byte to engine.
- O_spi_tx_start  out  1  engine start strobe.
- I_spi_busy  in  1  engine busy.
- I_spi_rx_data  in  8  engine received byte.

## Operation
- States: IDLE, CMD, ADDR, READ, HOLD, GAP.
- IDLE: with I_start high, capture I_addr and I_len, set O_busy. If I_len == 0, go to GAP without asserting CS. Otherwise assert O_spi_cs_n = 0 and go to CMD.
- Every byte is issued through the same sub-sequence: ISSUE → WAIT_HI → WAIT_LO.
  - ISSUE: O_spi_tx_start high for exactly one cycle, O_spi_tx_data valid in that cycle.
  - WAIT_HI: wait for I_spi_busy = 1. The engine raises busy one cycle after start.
  - WAIT_LO: wait for I_spi_busy = 0. The byte is complete and I_spi_rx_data is valid.
  - O_spi_tx_data is held constant from ISSUE until busy falls, because the engine latches data late.
- CMD: send CMD_READ, then go to ADDR.
- ADDR: send address bytes MSB first: [23:16], [15:8], [7:0]. A 2-bit counter selects the byte. Then go to READ.
- READ: send 8'h00. On completion, register I_spi_rx_data into O_data, set O_data_valid, decrement the remaining count, and go to HOLD.
- HOLD: wait for I_data_ready.
  - On handshake, clear O_data_valid.
  - If remaining ≠ 0, go to READ; the next ISSUE happens the following cycle.
  - Otherwise set O_spi_cs_n = 1 and go to GAP.
  - The engine is never started while O_data_valid is high; this is the back-pressure mechanism.
- GAP: count CS_GAP cycles with CS high. On the final cycle, pulse O_done, clear O_busy, and go to IDLE.
- I_start outside IDLE is ignored.
- Reset at any time: all state cleared. O_spi_cs_n = 1, O_spi_tx_start = 0, O_spi_tx_data = 0, O_data = 0, O_data_valid = 0, O_busy = 0, O_done = 0. An in-flight engine byte is abandoned; the engine finishes it with CS high, which is harmless.
- The remaining-byte counter is LEN_WIDTH bits, loaded with I_len and decremented once per received byte. No wrap is reachable, since len 0 is handled in IDLE.

## Timing
- All outputs are registered.
- I_start accepted at edge N: O_busy = 1 and O_spi_cs_n = 0 at N+1. The first O_spi_tx_start is at N+2.
- Byte period = 1 ISSUE cycle + engine busy time + 1 detect cycle.
- O_data_valid rises the cycle after I_spi_busy is observed low.
- Minimum O_data_valid duration: 1 cycle, when ready is already high.
- len = 0: O_done at cycle N+1+CS_GAP; O_spi_cs_n never goes low.
- O_done and the falling edge of O_busy occur in the same cycle. I_start is accepted again from the next cycle.

## Structure
- Shared package `spi_flash_pkg`:
  - state encoding localparams;
  - CMD_READ default (8'h03);
  - address byte count (3).
- No sub-module. The ISSUE/WAIT_HI/WAIT_LO handshake is a small nested state field in the same file; the engine is instantiated by the parent.

## Test plan
- addr = 0x123456, len = 2, ready tied high, engine model returns 0xA5, 0x5A → engine sees tx bytes 03, 12, 34, 56, 00, 00. O_data delivers A5 then 5A. CS is low throughout, then high; O_done pulses once, CS_GAP cycles after the last byte.
- len = 0 → O_busy high for CS_GAP cycles, O_done pulse, zero O_spi_tx_start pulses, CS stays high.
- Back-pressure: len = 3, ready held low 20 cycles per byte → O_data_valid holds a stable O_data. No tx_start is issued while valid is high; all 3 bytes arrive in order.
- I_start pulsed mid-transfer with a different addr → ignored. Byte stream and address bytes match the first request only.
- Reset asserted during ADDR phase → outputs take reset values asynchronously (CS_n = 1). A fresh request after release completes correctly.
- Engine tx_data stability: check O_spi_tx_data is unchanged from each start strobe until busy falls, for every byte.
